// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Brief    : Load/store request and response bundle between the memory-access
//            stage (master) and the data-memory responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_func3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_func3_i, req_addr_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_func3_i, req_addr_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Single-outstanding data-memory responder with alignment/range
//            checks, byte-lane stores and extended loads after wait states.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    dmem_responder_if.slave   bus
);

    localparam int          c_AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  c_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_rsp_valid;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [2:0]        r_func3;
    logic [1:0]        r_lane;
    logic [c_AW-1:0]   r_idx;
    logic              r_req_err;
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic [31:0]       w_offset;
    logic              w_oor;
    logic              w_illegal;
    logic              w_misalign;
    logic              w_err;
    logic              w_accept;
    logic [1:0]        w_lane;
    logic [c_AW-1:0]   w_idx;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;

    // Unsigned offset: addresses below BASE_ADDR wrap high and fall out of range.
    assign w_offset   = bus.req_addr_i - BASE_ADDR;
    assign w_oor      = {1'b0, w_offset} >= c_BYTES;
    assign w_lane     = bus.req_addr_i[1:0];
    assign w_idx      = w_offset[c_AW+1:2];
    assign w_illegal  = bus.req_we_i ? (bus.req_func3_i[2] | (bus.req_func3_i[1:0] == 2'b11))
                                     : ((bus.req_func3_i == 3'b011) | (bus.req_func3_i[2:1] == 2'b11));
    assign w_misalign = ((bus.req_func3_i[1:0] == 2'b01) & w_lane[0]) |
                        ((bus.req_func3_i[1:0] == 2'b10) & (w_lane != 2'b00));
    assign w_err      = w_oor | w_illegal | w_misalign;
    assign w_accept   = bus.req_valid_i & r_ready;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = bus.req_wdata_i;
        case (bus.req_func3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{bus.req_wdata_i[7:0]}};
            end
            2'b01: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.req_wdata_i[15:0]}};
            end
            2'b10: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // RAM contents survive reset; stores commit on the accept edge.
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_we_i && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign w_word = r_mem[r_idx];
    assign w_byte = w_word[8*r_lane +: 8];
    assign w_half = r_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load_data = 32'h0;
        case (r_func3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = w_word;
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_func3     <= 3'b000;
            r_lane      <= 2'b00;
            r_idx       <= '0;
            r_req_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we      <= bus.req_we_i;
                        r_func3   <= bus.req_func3_i;
                        r_lane    <= w_lane;
                        r_idx     <= w_idx;
                        r_req_err <= w_err;
                        r_ready   <= 1'b0;
                        r_cnt     <= c_WAIT;
                        r_state   <= S_WAIT;
                    end
                end
                // Counter starts at WAIT_CYCLES so the response rises after edge k+1+WAIT_CYCLES.
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_err       <= r_req_err;
                        r_rdata     <= (r_req_err || r_we) ? 32'h0 : w_load_data;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rdata     <= 32'h0;
                        r_err       <= 1'b0;
                        r_ready     <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready_o = r_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = r_rdata;
    assign bus.rsp_err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed bench: unit 0 (WAIT=1, BASE=0), unit 1 (WAIT=0, high BASE).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1)) u_dut0 (
        .clk (clk), .rst_n (rst_n), .bus (bus0.slave));
    dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(0)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1.slave));

    logic        t_valid  [2];
    logic        t_we     [2];
    logic [2:0]  t_f3     [2];
    logic [31:0] t_addr   [2];
    logic [31:0] t_wdata  [2];
    logic        t_rready [2];
    logic        o_ready  [2];
    logic        o_rvalid [2];
    logic [31:0] o_rdata  [2];
    logic        o_err    [2];

    assign bus0.req_valid_i = t_valid[0];
    assign bus0.req_we_i    = t_we[0];
    assign bus0.req_func3_i = t_f3[0];
    assign bus0.req_addr_i  = t_addr[0];
    assign bus0.req_wdata_i = t_wdata[0];
    assign bus0.rsp_ready_i = t_rready[0];
    assign bus1.req_valid_i = t_valid[1];
    assign bus1.req_we_i    = t_we[1];
    assign bus1.req_func3_i = t_f3[1];
    assign bus1.req_addr_i  = t_addr[1];
    assign bus1.req_wdata_i = t_wdata[1];
    assign bus1.rsp_ready_i = t_rready[1];
    assign o_ready[0]  = bus0.req_ready_o;
    assign o_rvalid[0] = bus0.rsp_valid_o;
    assign o_rdata[0]  = bus0.rsp_rdata_o;
    assign o_err[0]    = bus0.rsp_err_o;
    assign o_ready[1]  = bus1.req_ready_o;
    assign o_rvalid[1] = bus1.rsp_valid_o;
    assign o_rdata[1]  = bus1.rsp_rdata_o;
    assign o_err[1]    = bus1.rsp_err_o;

    int total = 0;
    int bad   = 0;

    // One full transaction; lat = edges from accept to the edge raising rsp_valid.
    task automatic xact(input int s, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        t_valid[s] = 1'b1; t_we[s] = we; t_f3[s] = f3; t_addr[s] = a; t_wdata[s] = wd;
        n = 0;
        while (o_ready[s] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        t_valid[s] = 1'b0;
        lat = 0;
        while (o_rvalid[s] !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        rd = o_rdata[s];
        er = o_err[s];
        t_rready[s] = 1'b1;
        @(negedge clk);
        t_rready[s] = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            total++; if (o_ready[s] !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d] got=%b exp=1", s, o_ready[s]); end
            total++; if (o_rvalid[s] !== 1'b0) begin bad++; $display("FAIL reset_rvalid[%0d] got=%b exp=0", s, o_rvalid[s]); end
            total++; if (o_rdata[s] !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d] got=%h exp=0", s, o_rdata[s]); end
            total++; if (o_err[s] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d] got=%b exp=0", s, o_err[s]); end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        xact(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
        total++; if (rd !== 32'h0 || er !== 1'b0 || lat != 2) begin bad++;
            $display("FAIL sw_rsp got rd=%h err=%b lat=%0d exp rd=0 err=0 lat=2", rd, er, lat); end
        xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != 2) begin bad++;
            $display("FAIL lw_rsp got rd=%h err=%b lat=%0d exp rd=deadbeef err=0 lat=2", rd, er, lat); end
    endtask

    task automatic test_extend();
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] exp [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};
        logic [31:0] rd; logic er; int lat;
        for (int i = 0; i < 4; i++) begin
            xact(0, 1'b0, f3[i], ad[i], 32'h0, rd, er, lat);
            total++; if (rd !== exp[i] || er !== 1'b0) begin bad++;
                $display("FAIL extend[%0d] got rd=%h err=%b exp rd=%h err=0", i, rd, er, exp[i]); end
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd; logic er; int lat;
        xact(0, 1'b1, 3'b000, 32'h11, 32'h0000_00AA, rd, er, lat);
        total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL sb_rsp got rd=%h err=%b exp rd=0 err=0", rd, er); end
        xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hDEAD_AAEF) begin bad++; $display("FAIL after_sb got=%h exp=deadaaef", rd); end
        xact(0, 1'b1, 3'b001, 32'h12, 32'h0000_1234, rd, er, lat);
        xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h1234_AAEF) begin bad++; $display("FAIL after_sh got=%h exp=1234aaef", rd); end
    endtask

    task automatic test_errors();
        logic        we  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3  [7] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b010, 3'b001};
        logic [31:0] ad  [7] = '{32'h11, 32'h13, 32'h1000, 32'h10, 32'h10, 32'h1010, 32'h11};
        logic [31:0] rd; logic er; int lat;
        for (int i = 0; i < 7; i++) begin
            xact(0, we[i], f3[i], ad[i], 32'hFFFF_FFFF, rd, er, lat);
            total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++;
                $display("FAIL err[%0d] got rd=%h err=%b exp rd=0 err=1", i, rd, er); end
        end
        xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h1234_AAEF || er !== 1'b0) begin bad++;
            $display("FAIL no_write got rd=%h err=%b exp rd=1234aaef err=0", rd, er); end
    endtask

    task automatic test_back_to_back();
        int n; int lat;
        @(negedge clk);
        t_valid[0] = 1'b1; t_we[0] = 1'b0; t_f3[0] = 3'b010; t_addr[0] = 32'h10;
        n = 0;
        while (o_ready[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        t_f3[0] = 3'b101; t_addr[0] = 32'h12;
        n = 0;
        while (o_rvalid[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        for (int c = 0; c < 5; c++) begin
            total++; if (o_rvalid[0] !== 1'b1 || o_rdata[0] !== 32'h1234_AAEF || o_err[0] !== 1'b0 || o_ready[0] !== 1'b0) begin bad++;
                $display("FAIL stall[%0d] got v=%b rd=%h err=%b rdy=%b exp v=1 rd=1234aaef err=0 rdy=0",
                         c, o_rvalid[0], o_rdata[0], o_err[0], o_ready[0]); end
            @(negedge clk);
        end
        t_rready[0] = 1'b1;
        @(negedge clk);
        t_rready[0] = 1'b0;
        total++; if (o_rvalid[0] !== 1'b0 || o_ready[0] !== 1'b1) begin bad++;
            $display("FAIL post_hs got v=%b rdy=%b exp v=0 rdy=1", o_rvalid[0], o_ready[0]); end
        @(negedge clk);
        t_valid[0] = 1'b0;
        total++; if (o_ready[0] !== 1'b0) begin bad++; $display("FAIL second_accept got rdy=%b exp 0", o_ready[0]); end
        lat = 0;
        while (o_rvalid[0] !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        total++; if (o_rdata[0] !== 32'h0000_1234 || lat != 2) begin bad++;
            $display("FAIL second_rsp got rd=%h lat=%0d exp rd=00001234 lat=2", o_rdata[0], lat); end
        t_rready[0] = 1'b1;
        @(negedge clk);
        t_rready[0] = 1'b0;
    endtask

    task automatic test_wait0();
        logic [31:0] rd; logic er; int lat; int n;
        xact(1, 1'b1, 3'b010, 32'h8000_0040, 32'hCAFE_F00D, rd, er, lat);
        total++; if (rd !== 32'h0 || er !== 1'b0 || lat != 1) begin bad++;
            $display("FAIL w0_sw got rd=%h err=%b lat=%0d exp rd=0 err=0 lat=1", rd, er, lat); end
        xact(1, 1'b0, 3'b010, 32'h8000_0040, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hCAFE_F00D || lat != 1) begin bad++;
            $display("FAIL w0_lw got rd=%h lat=%0d exp rd=cafef00d lat=1", rd, lat); end
        xact(1, 1'b0, 3'b001, 32'h8000_0042, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hFFFF_CAFE) begin bad++; $display("FAIL w0_lh got=%h exp=ffffcafe", rd); end
        xact(1, 1'b0, 3'b100, 32'h8000_0041, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0000_00F0) begin bad++; $display("FAIL w0_lbu got=%h exp=000000f0", rd); end
        xact(1, 1'b0, 3'b010, 32'h7FFF_FFFC, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL w0_below got rd=%h err=%b exp rd=0 err=1", rd, er); end
        xact(1, 1'b0, 3'b010, 32'h8000_0400, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL w0_above got rd=%h err=%b exp rd=0 err=1", rd, er); end
        // Held response with zero wait states.
        @(negedge clk);
        t_valid[1] = 1'b1; t_we[1] = 1'b0; t_f3[1] = 3'b010; t_addr[1] = 32'h8000_0040;
        n = 0;
        while (o_ready[1] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            total++; if (o_rvalid[1] !== 1'b1 || o_rdata[1] !== 32'hCAFE_F00D || o_ready[1] !== 1'b0) begin bad++;
                $display("FAIL w0_stall[%0d] got v=%b rd=%h rdy=%b exp v=1 rd=cafef00d rdy=0", c, o_rvalid[1], o_rdata[1], o_ready[1]); end
            @(negedge clk);
        end
        t_valid[1] = 1'b0;
        t_rready[1] = 1'b1;
        @(negedge clk);
        t_rready[1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int n; logic seen;
        @(negedge clk);
        t_valid[0] = 1'b1; t_we[0] = 1'b0; t_f3[0] = 3'b010; t_addr[0] = 32'h10;
        n = 0;
        while (o_ready[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        t_valid[0] = 1'b0;
        total++; if (o_ready[0] !== 1'b0) begin bad++; $display("FAIL mid_busy got rdy=%b exp 0", o_ready[0]); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (o_ready[0] !== 1'b1 || o_rvalid[0] !== 1'b0) begin bad++;
            $display("FAIL mid_async got rdy=%b v=%b exp rdy=1 v=0", o_ready[0], o_rvalid[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (o_rvalid[0] !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_no_rsp got spurious=%b exp 0", seen); end
        xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h1234_AAEF || er !== 1'b0 || lat != 2) begin bad++;
            $display("FAIL mid_reload got rd=%h err=%b lat=%0d exp rd=1234aaef err=0 lat=2", rd, er, lat); end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            t_valid[s] = 1'b0; t_we[s] = 1'b0; t_f3[s] = 3'b000;
            t_addr[s] = 32'h0; t_wdata[s] = 32'h0; t_rready[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_store_load();
        test_extend();
        test_partial_store();
        test_errors();
        test_back_to_back();
        test_wait0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
